instr_decode_stage: RTL
=======================

# instr_decode_stage

Parametrised decode stage for the CaballoLoco core: accepts raw instruction words from fetch over a valid/ready handshake and splits them into fields and control strobes for the 14-entry opcode set (OR..NOP). It sign-extends offsets and holds a one-entry output register toward execute. A per-register scoreboard stalls read-after-write and write-after-write hazards until writeback clears the pending destination.

## Interface
- DATA_W, 32: datapath / PC / immediate output width.
- REG_W, 5: register index width; NUM_REGS = 2**REG_W.
- IMM_W, 13: low immediate field width; INSTR_W = 4 + 3*REG_W + IMM_W (32 at defaults).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid / in_ready  in / out  1  fetch handshake.
- in_instr  in  INSTR_W  instruction word; in_pc  in  DATA_W  its PC.
- flush  in  1  drop held instruction (taken branch in execute).
- wb_valid  in  1; wb_rd  in  REG_W: writeback completion, clears scoreboard bit.
- out_valid / out_ready  out / in  1  execute handshake.
- out_op  out  4  opcode (opcodes_e encoding); out_ra, out_rb, out_rd  out  REG_W.
- out_imm  out  DATA_W  sign-extended offset; out_pc  out  DATA_W.
- out_we, out_mem_rd, out_mem_wr, out_branch, out_jump  out  1  control strobes.
- out_illegal  out  1  illegal-opcode flag.
- busy_mask  out  NUM_REGS  scoreboard contents.

## Operation
- Fields: op = instr[INSTR_W-1 -: 4], ra next REG_W bits, then rb, then rc, imm = low IMM_W bits.
- OR/ADD/SUB/AND/MUL/DIV/XOR (0-6): reads ra, rb; writes rd=rc; out_we=1, out_imm=0.
- LW (7): reads ra; rd=rc; offset = sext({rb,imm}); out_we=1, out_mem_rd=1.
- SW (8): reads ra, rb; offset = sext({rc,imm}); out_mem_wr=1.
- BEQ/BLT/BLE (9-11): reads ra, rb; offset = sext({rc,imm}); out_branch=1.
- JMP (12): offset = sext(instr[INSTR_W-5:0]); out_jump=1, no reads.
- NOP (13): all strobes 0.
- Codes 14-15: illegal, see Configuration.
- Register 0 is never a hazard and never set in busy_mask; ops with rd=0 present out_we=0.
- Hazard = any read source or rd (when out_we) is set in (busy_mask after same-cycle wb clear) OR equals out_rd of a held out_valid entry with out_we=1.
- Scoreboard bit for rd set on output handshake (out_valid && out_ready && out_we), cleared on wb_valid. Same-cycle set and clear of one register: set wins.
- Flush: out_valid cleared next edge, no scoreboard change, in_ready=0 in the flush cycle; flush beats a simultaneous in/out handshake.

## Timing
- Reset: out_valid=0, all out_* fields and strobes 0, out_illegal=0, busy_mask=0.
- Latency 1 cycle: accepted on edge N, visible on out_* after edge N.
- in_ready = !flush && !hazard && (!out_valid || out_ready) && !illegal_hold; combinational, no in_valid dependency.
- Back-to-back throughput 1/cycle when hazard-free and out_ready=1.
- out_* stable while out_valid && !out_ready.
- wb clear is visible to hazard check in the same cycle (bypass).
- Reset mid-operation: held instruction and all pending busy bits lost.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined: opcode 14/15 is accepted, presented with out_illegal=1 and all strobes 0; after it leaves the stage, illegal_hold forces in_ready=0 until flush is asserted.
- Undefined: opcode 14/15 decoded exactly as NOP, out_illegal tied 0, no hold.

## Test plan
- Reset then ADD ra=1 rb=2 rc=3 with out_ready=1 -> next cycle out_op=1, out_rd=3, out_we=1; after handshake busy_mask[3]=1.
- LW rc=4 followed by SUB ra=4 -> SUB stalled (in_ready=0) until wb_valid with wb_rd=4; accepted same cycle as wb.
- BEQ with rc=5'h1F, imm=13'h1FFF -> out_imm=32'hFFFFFFFF, out_branch=1; JMP instr[27:0]=28'h0000010 -> out_imm=16, out_jump=1.
- out_ready=0 for 3 cycles with valid XOR held -> out_* unchanged, in_ready=0; flush -> out_valid=0, busy_mask unchanged.
- ADD rc=0 -> out_we=0, busy_mask stays 0; next instr reading r0 not stalled.
- Opcode 15: with DECODE_ILLEGAL_TRAP_EN -> out_illegal=1 then in_ready=0 until flush; without -> NOP, out_illegal=0, flow continues.

Source files
------------

// File: rtl/instr_decode_stage.sv
// CaballoLoco decode stage: field split, control strobes, offset sign-extension,
// one-entry output register and RAW/WAW scoreboard. Optional: DECODE_ILLEGAL_TRAP_EN.

module idec_sb_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic busy
);
  // Set wins over a same-cycle writeback clear of the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   busy <= 1'b0;
    else if (set) busy <= 1'b1;
    else if (clr) busy <= 1'b0;
  end
endmodule

module instr_decode_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int IMM_W  = 13,
  localparam int NUM_REGS = 2**REG_W,
  localparam int INSTR_W  = 4 + 3*REG_W + IMM_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic [DATA_W-1:0]   in_pc,
  input  logic                flush,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_op,
  output logic [REG_W-1:0]    out_ra,
  output logic [REG_W-1:0]    out_rb,
  output logic [REG_W-1:0]    out_rd,
  output logic [DATA_W-1:0]   out_imm,
  output logic [DATA_W-1:0]   out_pc,
  output logic                out_we,
  output logic                out_mem_rd,
  output logic                out_mem_wr,
  output logic                out_branch,
  output logic                out_jump,
  output logic                out_illegal,
  output logic [NUM_REGS-1:0] busy_mask
);

  localparam int OFF_W = REG_W + IMM_W;
  localparam int JMP_W = INSTR_W - 4;

  typedef enum logic [3:0] {
    OP_OR, OP_ADD, OP_SUB, OP_AND, OP_MUL, OP_DIV, OP_XOR, OP_LW,
    OP_SW, OP_BEQ, OP_BLT, OP_BLE, OP_JMP, OP_NOP, OP_RSV14, OP_RSV15
  } opcodes_e;

  typedef struct packed {
    logic [3:0]        op;
    logic [REG_W-1:0]  ra;
    logic [REG_W-1:0]  rb;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic              we;
    logic              mem_rd;
    logic              mem_wr;
    logic              branch;
    logic              jump;
    logic              illegal;
  } dec_t;

  logic [3:0]       f_op;
  logic [REG_W-1:0] f_ra, f_rb, f_rc;
  logic [IMM_W-1:0] f_imm;
  logic [OFF_W-1:0] off_rb, off_rc;
  logic [JMP_W-1:0] off_jmp;

  assign {f_op, f_ra, f_rb, f_rc, f_imm} = in_instr;
  assign off_rb  = {f_rb, f_imm};
  assign off_rc  = {f_rc, f_imm};
  assign off_jmp = in_instr[JMP_W-1:0];

  dec_t dec, q;
  logic rd_a, rd_b;

  always_comb begin
    dec    = '0;
    rd_a   = 1'b0;
    rd_b   = 1'b0;
    dec.op = f_op;
    dec.pc = in_pc;
    case (opcodes_e'(f_op))
      OP_OR, OP_ADD, OP_SUB, OP_AND, OP_MUL, OP_DIV, OP_XOR: begin
        rd_a   = 1'b1;
        rd_b   = 1'b1;
        dec.rd = f_rc;
        dec.we = |f_rc;
      end
      OP_LW: begin
        rd_a       = 1'b1;
        dec.rd     = f_rc;
        dec.we     = |f_rc;
        dec.mem_rd = 1'b1;
        dec.imm    = {{(DATA_W-OFF_W){off_rb[OFF_W-1]}}, off_rb};
      end
      OP_SW: begin
        rd_a       = 1'b1;
        rd_b       = 1'b1;
        dec.mem_wr = 1'b1;
        dec.imm    = {{(DATA_W-OFF_W){off_rc[OFF_W-1]}}, off_rc};
      end
      OP_BEQ, OP_BLT, OP_BLE: begin
        rd_a       = 1'b1;
        rd_b       = 1'b1;
        dec.branch = 1'b1;
        dec.imm    = {{(DATA_W-OFF_W){off_rc[OFF_W-1]}}, off_rc};
      end
      OP_JMP: begin
        dec.jump = 1'b1;
        dec.imm  = {{(DATA_W-JMP_W){off_jmp[JMP_W-1]}}, off_jmp};
      end
`ifdef DECODE_ILLEGAL_TRAP_EN
      OP_RSV14, OP_RSV15: dec.illegal = 1'b1;
`else
      OP_RSV14, OP_RSV15: dec.op = OP_NOP;
`endif
      default: ;
    endcase
    // A read of r0 is encoded as ra/rb = 0, which the hazard check ignores.
    dec.ra = rd_a ? f_ra : '0;
    dec.rb = rd_b ? f_rb : '0;
  end

  // Hazard check sees the writeback clear of this cycle (bypass).
  logic [NUM_REGS-1:0] wb_clr, sb_set, busy_eff;
  logic held_w, haz_a, haz_b, haz_d, hazard, illegal_hold, accept, leave;

  assign wb_clr   = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;
  assign busy_eff = busy_mask & ~wb_clr;
  assign held_w   = out_valid && q.we;
  assign haz_a    = (dec.ra != '0) && (busy_eff[dec.ra] || (held_w && q.rd == dec.ra));
  assign haz_b    = (dec.rb != '0) && (busy_eff[dec.rb] || (held_w && q.rd == dec.rb));
  assign haz_d    = dec.we && (busy_eff[dec.rd] || (held_w && q.rd == dec.rd));
  assign hazard   = haz_a || haz_b || haz_d;

  assign in_ready = !flush && !hazard && (!out_valid || out_ready) && !illegal_hold;
  assign accept   = in_valid && in_ready;
  assign leave    = out_valid && out_ready && !flush;
  assign sb_set   = (leave && q.we) ? (NUM_REGS'(1) << q.rd) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      q         <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Once a trapping word has gone to execute, nothing follows until the redirect flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  illegal_hold <= 1'b0;
    else if (flush)              illegal_hold <= 1'b0;
    else if (leave && q.illegal) illegal_hold <= 1'b1;
  end
`else
  assign illegal_hold = 1'b0;
`endif

  assign busy_mask[0] = 1'b0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_sb
    idec_sb_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (sb_set[i]),
      .clr   (wb_clr[i]),
      .busy  (busy_mask[i])
    );
  end

  assign out_op      = q.op;
  assign out_ra      = q.ra;
  assign out_rb      = q.rb;
  assign out_rd      = q.rd;
  assign out_imm     = q.imm;
  assign out_pc      = q.pc;
  assign out_we      = q.we;
  assign out_mem_rd  = q.mem_rd;
  assign out_mem_wr  = q.mem_wr;
  assign out_branch  = q.branch;
  assign out_jump    = q.jump;
  assign out_illegal = q.illegal;

endmodule
